// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT frame sequencer.
package fft_pkg;

  localparam int FFT_N    = 8;
  localparam int IDX_W    = 3;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN
  } fft_ctrl_state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fft_frame_ctrl.sv
// Load / compute / drain sequencer around a combinational 8-point FFT core:
// deserialises 8 samples onto the core inputs, waits for settling, then streams the 8 bins out.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int DW         = 16,
  parameter int SETTLE_CYC = 2,
  parameter int FCNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_re,
  input  logic [DW-1:0]         s_im,
  input  logic                  s_mode,
  output logic [FFT_N*DW-1:0]   core_xr,
  output logic [FFT_N*DW-1:0]   core_xi,
  output logic                  core_mode,
  input  logic [FFT_N*DW-1:0]   core_yr,
  input  logic [FFT_N*DW-1:0]   core_yi,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_re,
  output logic [DW-1:0]         m_im,
  output logic [IDX_W-1:0]      m_idx,
  output logic                  m_last,
  output logic                  busy,
  output logic [FCNT_W-1:0]     frame_cnt
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_N - 1);

  fft_ctrl_state_t r_state;
  fft_ctrl_state_t w_state_nxt;

  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_midx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode;
  logic [FCNT_W-1:0] r_fcnt;
  logic [DW-1:0]     r_xr [FFT_N];
  logic [DW-1:0]     r_xi [FFT_N];
  logic [DW-1:0]     r_yr [FFT_N];
  logic [DW-1:0]     r_yi [FFT_N];

  logic w_s_hs;
  logic w_m_hs;
  logic w_load_done;
  logic w_settled;
  logic w_drain_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stream-side outputs are decoded from state so they stay bit-stable while stalled.
  always_comb begin
    w_state_nxt  = r_state;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    busy         = 1'b1;
    w_s_hs       = 1'b0;
    w_m_hs       = 1'b0;
    w_load_done  = 1'b0;
    w_settled    = 1'b0;
    w_drain_done = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        s_ready     = 1'b1;
        busy        = (r_idx != '0);
        w_s_hs      = s_valid;
        w_load_done = s_valid && (r_idx == IDX_LAST);
        if (w_load_done) begin
          w_state_nxt = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        w_settled = (r_cnt == '0);
        if (w_settled) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        m_valid      = 1'b1;
        m_last       = (r_midx == IDX_LAST);
        w_m_hs       = m_ready;
        w_drain_done = m_ready && (r_midx == IDX_LAST);
        if (w_drain_done) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= '0;
      r_midx <= '0;
      r_cnt  <= '0;
      r_mode <= 1'b0;
      r_fcnt <= '0;
      for (int unsigned k = 0; k < FFT_N; k++) begin
        r_xr[k] <= '0;
        r_xi[k] <= '0;
        r_yr[k] <= '0;
        r_yi[k] <= '0;
      end
    end else begin
      if (w_s_hs) begin
        r_xr[r_idx] <= s_re;
        r_xi[r_idx] <= s_im;
        r_idx       <= r_idx + 1'b1;
        if (r_idx == '0) begin
          r_mode <= s_mode;
        end
      end

      if (w_load_done) begin
        r_cnt <= CNT_LOAD;
      end else if ((r_state == ST_COMPUTE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_settled) begin
        r_midx <= '0;
        for (int unsigned k = 0; k < FFT_N; k++) begin
          r_yr[k] <= core_yr[k*DW +: DW];
          r_yi[k] <= core_yi[k*DW +: DW];
        end
      end

      if (w_m_hs) begin
        r_midx <= r_midx + 1'b1;
      end

      if (w_drain_done) begin
        r_fcnt <= r_fcnt + 1'b1;
        r_idx  <= '0;
      end
    end
  end

  always_comb begin
    core_xr = '0;
    core_xi = '0;
    for (int unsigned k = 0; k < FFT_N; k++) begin
      core_xr[k*DW +: DW] = r_xr[k];
      core_xi[k*DW +: DW] = r_xi[k];
    end
  end

  assign core_mode = r_mode;
  assign m_re      = r_yr[r_midx];
  assign m_im      = r_yi[r_midx];
  assign m_idx     = r_midx;
  assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: table frames with hand-derived bins, corner sequences,
// and random traffic against a frame-level reference model. An integer DFT stands in for the core.
module tb_fft_frame_ctrl;

  localparam int DW     = 16;
  localparam int SETTLE = 2;
  localparam int FCNT_W = 3;
  localparam int N      = 8;
  localparam int CW     = N * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_re;
  logic [DW-1:0] s_im;
  logic          s_mode;
  logic [CW-1:0] core_xr;
  logic [CW-1:0] core_xi;
  logic          core_mode;
  logic [CW-1:0] core_yr;
  logic [CW-1:0] core_yi;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_re;
  logic [DW-1:0] m_im;
  logic [2:0]    m_idx;
  logic          m_last;
  logic          busy;
  logic [FCNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  fft_frame_ctrl #(
    .DW(DW),
    .SETTLE_CYC(SETTLE),
    .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_mode(s_mode),
    .core_xr(core_xr), .core_xi(core_xi), .core_mode(core_mode),
    .core_yr(core_yr), .core_yi(core_yi),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_last(m_last), .busy(busy), .frame_cnt(frame_cnt)
  );

  // Twiddles scaled by 2^14; W^(m+4) = -W^m exactly, so symmetric inputs cancel to 0.
  function automatic int cosq(input int m);
    case (m)
      0: return 16384;  1: return 11585;  2: return 0;      3: return -11585;
      4: return -16384; 5: return -11585; 6: return 0;      default: return 11585;
    endcase
  endfunction

  function automatic int sinq(input int m);
    case (m)
      0: return 0;      1: return 11585;  2: return 16384;  3: return 11585;
      4: return 0;      5: return -11585; 6: return -16384; default: return -11585;
    endcase
  endfunction

  function automatic logic [2*DW-1:0] dft_bin(input logic [CW-1:0] xr, input logic [CW-1:0] xi,
                                              input logic inv, input int k);
    longint ar, ai, a, b, tr, ti;
    int m, c, s;
    ar = 0;
    ai = 0;
    for (int n = 0; n < N; n++) begin
      a  = longint'($signed(xr[n*DW +: DW]));
      b  = longint'($signed(xi[n*DW +: DW]));
      m  = (k * n) % N;
      c  = cosq(m);
      s  = inv ? -sinq(m) : sinq(m);
      ar = ar + a * longint'(c) + b * longint'(s);
      ai = ai + b * longint'(c) - a * longint'(s);
    end
    tr = ar >>> 14;
    ti = ai >>> 14;
    return {tr[DW-1:0], ti[DW-1:0]};
  endfunction

  logic [2*DW-1:0] w_bin;
  always_comb begin
    core_yr = '0;
    core_yi = '0;
    w_bin   = '0;
    for (int k = 0; k < N; k++) begin
      w_bin = dft_bin(core_xr, core_xi, core_mode, k);
      core_yr[k*DW +: DW] = w_bin[2*DW-1:DW];
      core_yi[k*DW +: DW] = w_bin[DW-1:0];
    end
  end

  typedef struct {
    logic          mode;
    logic [DW-1:0] xr [N];
    logic [DW-1:0] xi [N];
    logic [DW-1:0] yr [N];
    logic [DW-1:0] yi [N];
  } vec_t;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          mode;
    int            gap;
    int            tab;
  } tx_t;

  vec_t tab [4];
  tx_t  txq [$];
  int   pres_tab;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_run;

  // Frame-level reference model
  logic [DW-1:0] mx_re [N];
  logic [DW-1:0] mx_im [N];
  logic          mmode;
  int            n_in, out_i, ready_at, fcnt, cur_tab;
  logic [DW-1:0] eq_re [$];
  logic [DW-1:0] eq_im [$];

  function automatic logic [CW-1:0] pack(input logic [DW-1:0] a [N]);
    logic [CW-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k*DW +: DW] = a[k];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    n_in     = 0;
    out_i    = 0;
    fcnt     = 0;
    ready_at = 0;
    mmode    = 1'b0;
    cur_tab  = -1;
    eq_re.delete();
    eq_im.delete();
    for (int k = 0; k < N; k++) begin
      mx_re[k] = '0;
      mx_im[k] = '0;
    end
  endtask

  task automatic cycle(output bit hs);
    bit mv_e;
    logic [2*DW-1:0] b;
    mv_e = (eq_re.size() != 0) && (cyc >= ready_at);
    chk("s_ready", CW'(s_ready), CW'(eq_re.size() == 0));
    chk("m_valid", CW'(m_valid), CW'(mv_e));
    chk("busy", CW'(busy), CW'((n_in != 0) || (eq_re.size() != 0)));
    chk("core_xr", core_xr, pack(mx_re));
    chk("core_xi", core_xi, pack(mx_im));
    chk("core_mode", CW'(core_mode), CW'(mmode));
    chk("frame_cnt", CW'(frame_cnt), CW'(fcnt % (1 << FCNT_W)));
    if (mv_e) begin
      chk("m_re", CW'(m_re), CW'(eq_re[out_i]));
      chk("m_im", CW'(m_im), CW'(eq_im[out_i]));
      chk("m_idx", CW'(m_idx), CW'(out_i));
      chk("m_last", CW'(m_last), CW'(out_i == N - 1));
    end
    hs = 1'b0;
    if (!reset) begin
      if (s_valid && (eq_re.size() == 0)) begin
        hs = 1'b1;
        if (n_in == 0) begin
          mmode   = s_mode;
          cur_tab = pres_tab;
        end
        mx_re[n_in] = s_re;
        mx_im[n_in] = s_im;
        n_in++;
        if (n_in == N) begin
          for (int k = 0; k < N; k++) begin
            if (cur_tab >= 0) begin
              eq_re.push_back(tab[cur_tab].yr[k]);
              eq_im.push_back(tab[cur_tab].yi[k]);
            end else begin
              b = dft_bin(pack(mx_re), pack(mx_im), mmode, k);
              eq_re.push_back(b[2*DW-1:DW]);
              eq_im.push_back(b[DW-1:0]);
            end
          end
          ready_at = cyc + SETTLE + 1;
          n_in     = 0;
          out_i    = 0;
        end
      end else if (mv_e && m_ready) begin
        out_i++;
        if (out_i == N) begin
          eq_re.delete();
          eq_im.delete();
          out_i = 0;
          fcnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) model_reset();
  endtask

  task automatic enqueue_tab(input int id, input int gap_at, input int gap_len);
    tx_t t;
    for (int i = 0; i < N; i++) begin
      t.re   = tab[id].xr[i];
      t.im   = tab[id].xi[i];
      t.mode = (i == 0) ? tab[id].mode : ~tab[id].mode;
      t.gap  = (i == gap_at) ? gap_len : 0;
      t.tab  = id;
      txq.push_back(t);
    end
  endtask

  task automatic enqueue_rand(input int gmax);
    tx_t t;
    for (int i = 0; i < N; i++) begin
      t.re   = DW'($urandom_range(0, 2047)) - DW'(1024);
      t.im   = DW'($urandom_range(0, 2047)) - DW'(1024);
      t.mode = 1'($urandom_range(0, 1));
      t.gap  = int'($urandom_range(0, gmax));
      t.tab  = -1;
      txq.push_back(t);
    end
  endtask

  // pol: 0 = m_ready always high, 1 = pattern 1,0,0,..., 2 = random
  task automatic run(input int pol, input int budget, input int stop_out);
    int n;
    int tog;
    bit hs;
    n   = 0;
    tog = 0;
    while ((txq.size() != 0) || (n_in != 0) || (eq_re.size() != 0)) begin
      if ((stop_out >= 0) && (eq_re.size() != 0) && (out_i == stop_out) && (cyc >= ready_at)) break;
      if (n >= budget) begin
        total++;
        bad++;
        $display("FAIL timeout cyc=%0d got=%0d cycles want<%0d", cyc, n, budget);
        break;
      end
      if ((txq.size() != 0) && (txq[0].gap == 0)) begin
        s_valid  = 1'b1;
        s_re     = txq[0].re;
        s_im     = txq[0].im;
        s_mode   = txq[0].mode;
        pres_tab = txq[0].tab;
      end else begin
        s_valid = 1'b0;
        s_re    = DW'($urandom);
        s_im    = DW'($urandom);
        s_mode  = 1'($urandom_range(0, 1));
      end
      case (pol)
        0:       m_ready = 1'b1;
        1:       m_ready = ((tog % 3) == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      tog++;
      cycle(hs);
      if (hs) begin
        void'(txq.pop_front());
      end else if ((txq.size() != 0) && (txq[0].gap > 0)) begin
        txq[0].gap = txq[0].gap - 1;
      end
      n++;
    end
    s_valid  = 1'b0;
    last_run = n;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, CW'(m_valid), '0);
    chk({tag, "_s_ready"}, CW'(s_ready), CW'(1'b1));
    chk({tag, "_busy"}, CW'(busy), '0);
    chk({tag, "_m_last"}, CW'(m_last), '0);
    chk({tag, "_m_idx"}, CW'(m_idx), '0);
    chk({tag, "_m_re"}, CW'(m_re), '0);
    chk({tag, "_m_im"}, CW'(m_im), '0);
    chk({tag, "_core_xr"}, core_xr, '0);
    chk({tag, "_core_xi"}, core_xi, '0);
    chk({tag, "_core_mode"}, CW'(core_mode), '0);
    chk({tag, "_frame_cnt"}, CW'(frame_cnt), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=no finish want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hs;

    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < N; k++) begin
        tab[t].xr[k] = '0;
        tab[t].xi[k] = '0;
        tab[t].yr[k] = '0;
        tab[t].yi[k] = '0;
      end
    end
    tab[0].mode = 1'b0;
    tab[0].xr[0] = 16'h1000;
    for (int k = 0; k < N; k++) tab[0].yr[k] = 16'h1000;
    tab[1].mode = 1'b0;
    for (int k = 0; k < N; k++) tab[1].xr[k] = 16'h0100;
    tab[1].yr[0] = 16'h0800;
    tab[2].mode = 1'b1;
    for (int k = 0; k < N; k++) tab[2].xr[k] = (k % 2 == 0) ? 16'h0040 : 16'hFFC0;
    tab[2].yr[4] = 16'h0200;
    tab[3].mode = 1'b0;
    tab[3].xi[0] = 16'h0300;
    for (int k = 0; k < N; k++) tab[3].yi[k] = 16'h0300;

    reset    = 1'b1;
    s_valid  = 1'b0;
    s_re     = '0;
    s_im     = '0;
    s_mode   = 1'b0;
    m_ready  = 1'b0;
    pres_tab = -1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_reset_outputs("por");
    reset = 1'b0;

    // Table frames: impulse, DC, alternating IFFT, imaginary impulse
    for (int t = 0; t < 4; t++) begin
      enqueue_tab(t, -1, 0);
      run(0, 100, -1);
    end
    chk("tab_fcnt", CW'(frame_cnt), CW'(3'd4));

    enqueue_tab(0, -1, 0);
    run(1, 200, -1);

    enqueue_tab(2, -1, 0);
    run(0, 100, -1);
    chk("mode_latch_ifft", CW'(core_mode), CW'(1'b1));
    enqueue_tab(1, -1, 0);
    run(0, 100, -1);
    chk("mode_latch_fft", CW'(core_mode), '0);

    enqueue_tab(1, 5, 3);
    run(0, 100, -1);
    chk("gap_core_xr", core_xr, pack(tab[1].xr));
    chk("gap_cycles", CW'(last_run), CW'(2 * N + SETTLE + 3));

    enqueue_tab(0, -1, 0);
    run(0, 100, 3);
    chk("pre_reset_m_idx", CW'(m_idx), CW'(3'd3));
    reset = 1'b1;
    m_ready = 1'b1;
    cycle(hs);
    reset = 1'b0;
    chk_reset_outputs("mid_drain");
    enqueue_tab(3, -1, 0);
    run(0, 100, -1);
    chk("post_reset_fcnt", CW'(frame_cnt), CW'(3'd1));

    reset = 1'b1;
    cycle(hs);
    reset = 1'b0;
    for (int f = 0; f < 3; f++) enqueue_rand(0);
    run(0, 200, -1);
    chk("tput_fcnt", CW'(frame_cnt), CW'(3'd3));
    chk("tput_cycles", CW'(last_run), CW'(3 * (2 * N + SETTLE)));

    for (int f = 0; f < 40; f++) enqueue_rand(2);
    run(2, 4000, -1);
    chk("rand_fcnt", CW'(frame_cnt), CW'((3 + 40) % (1 << FCNT_W)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
